multi_edge_detect: RTL and testbench
====================================

Name: multi_edge_detect

Overview:
Parametrised multi-channel edge detector for asynchronous or noisy inputs such as buttons, switches and sensor strobes. Each channel has an input synchroniser, a debounce filter, per-channel rising/falling edge enables, a stretchable output pulse and a sticky pending flag with clear. Sits between raw FPGA inputs and control FSMs, which consume either the single-cycle pulses or the latched flags.

Parameters:
WIDTH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=1)
DEBOUNCE_CYCLES, 1, consecutive cycles a new value must persist before it is accepted (>=1; 1 = no filtering)
PULSE_LEN, 1, cycles each output pulse is held high (>=1)

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
in  input  WIDTH  raw channel inputs, may be asynchronous
rise_en  input  WIDTH  per-channel enable for rising-edge events
fall_en  input  WIDTH  per-channel enable for falling-edge events
clear  input  WIDTH  per-channel clear of pending flag
level  output  WIDTH  debounced, synchronised channel level
pulse  output  WIDTH  edge pulse, PULSE_LEN cycles per accepted event
pending  output  WIDTH  sticky event flag, held until cleared
any_event  output  1  OR of all pending bits, registered

Behaviour:
- Reset (clock edge with reset=1): sync chains, level, debounce counters, pulse counters, pulse, pending, any_event all cleared to 0. Reset mid-pulse or mid-debounce aborts it; no event is produced for that edge.
- Synchroniser: SYNC_STAGES-flop shift chain per channel; the last stage is s.
- Debounce: per-channel counter cnt, width clog2(DEBOUNCE_CYCLES)+1.
  - s == level: cnt <= 0.
  - s != level and cnt == DEBOUNCE_CYCLES-1: level <= s, cnt <= 0; this is an accepted transition.
  - s != level otherwise: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at s resets cnt and is never accepted.
- Latency: an input change sampled at edge k appears on level at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults, 2 edges.
- Event: an accepted 0->1 transition with rise_en=1, or 1->0 with fall_en=1. Enables are sampled at the acceptance edge. A disabled transition still updates level but produces no pulse and no pending.
- Since level resets to 0, an input held high through reset yields a rising event after latency.
- Pulse: an event loads the pulse counter with PULSE_LEN and pulse goes high at the same edge level changes. pulse stays high while counter>0 and the counter decrements each cycle, so pulse is high for exactly PULSE_LEN cycles. A new event during a pulse reloads to PULSE_LEN (retrigger extends, never doubles).
- Pending: set at the event edge. Cleared at an edge where clear=1 and no event occurs. If clear and an event occur at the same edge, set wins (pending=1).
- any_event: registered OR of next-state pending. It changes on the same edge as pending.
- Channels are fully independent; simultaneous events on several channels are all honoured.

Test Plan:
1. Defaults, rise_en=4'hF, fall_en=0. Raise in[0] at edge 10 -> level[0] and pulse[0] high at edge 12, pulse[0] low at edge 13, pending[0]=1 and any_event=1 from edge 12. in[0] falls at edge 20 -> level[0] low at edge 22, no pulse.
2. DEBOUNCE_CYCLES=4. in[1] high for 3 cycles then low -> level[1] stays 0, no pulse. in[1] high for 4 cycles -> level[1] rises 5 edges after the input change, one pulse.
3. PULSE_LEN=3, fall_en[2]=1. Falling edge -> pulse[2] high exactly 3 cycles. A second accepted falling edge 2 cycles into the pulse reloads the counter: total high time = 2+3 = 5 cycles.
4. Assert clear[3] on the same edge an event is accepted on channel 3 -> pending[3]=1. clear[3] on the next edge with no event -> pending[3]=0, any_event=0.
5. Hold in=4'hF through reset, release reset at edge 5 -> all four channels produce a rising pulse at edge 7. Assert reset at edge 8 during PULSE_LEN=3 pulses -> all outputs 0 at edge 8.
6. Drive in[0] and in[2] high on the same edge -> pulse=4'b0101 on the same cycle, pending=4'b0101.

Source files
------------

// File: rtl/multi_edge_detect.sv
// -----------------------------------------------------------------------------
// multi_edge_detect
//
// Multi-channel edge detector for asynchronous or noisy inputs such as buttons,
// switches and sensor strobes. Each channel is synchronised, debounced and then
// turned into a stretchable pulse and a sticky pending flag.
//
// Parameters:
//   WIDTH           number of independent channels (>=1)
//   SYNC_STAGES     synchroniser flops per channel (>=1)
//   DEBOUNCE_CYCLES consecutive cycles a new value must persist (>=1, 1 = none)
//   PULSE_LEN       cycles each output pulse is held high (>=1)
//
// Ports:
//   clock      system clock, all state updates on its rising edge
//   reset      synchronous, active-high reset
//   in         raw channel inputs, may be asynchronous
//   rise_en    per-channel enable for rising-edge events
//   fall_en    per-channel enable for falling-edge events
//   clear      per-channel clear of the pending flag
//   level      debounced, synchronised channel level
//   pulse      edge pulse, PULSE_LEN cycles per accepted event
//   pending    sticky event flag, held until cleared
//   any_event  registered OR of all pending bits
// -----------------------------------------------------------------------------
module multi_edge_detect #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int PULSE_LEN       = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] clear,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] pending,
    output logic             any_event
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int PCNT_W = $clog2(PULSE_LEN + 1);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PCNT_ZERO = {PCNT_W{1'b0}};
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
    localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PULSE_LEN);

    logic [WIDTH-1:0]  sync_r [SYNC_STAGES];
    logic [WIDTH-1:0]  s_s;
    logic [CNT_W-1:0]  cnt_r       [WIDTH];
    logic [CNT_W-1:0]  cnt_next_s  [WIDTH];
    logic [PCNT_W-1:0] pcnt_r      [WIDTH];
    logic [PCNT_W-1:0] pcnt_next_s [WIDTH];
    logic [WIDTH-1:0]  level_r;
    logic [WIDTH-1:0]  level_next_s;
    logic [WIDTH-1:0]  accept_s;
    logic [WIDTH-1:0]  event_s;
    logic [WIDTH-1:0]  pulse_r;
    logic [WIDTH-1:0]  pulse_next_s;
    logic [WIDTH-1:0]  pending_r;
    logic [WIDTH-1:0]  pending_next_s;
    logic              any_event_r;

    // The last synchroniser stage is the clean per-channel sample.
    assign s_s = sync_r[SYNC_STAGES-1];

    // Debounce, event qualification, pulse stretching and pending next-state.
    always_comb begin
        level_next_s   = level_r;
        accept_s       = {WIDTH{1'b0}};
        event_s        = {WIDTH{1'b0}};
        pulse_next_s   = {WIDTH{1'b0}};
        pending_next_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next_s[i]  = CNT_ZERO;
            pcnt_next_s[i] = PCNT_ZERO;

            // A new value is accepted only after it has differed from level
            // for DEBOUNCE_CYCLES consecutive samples.
            if (s_s[i] == level_r[i]) begin
                cnt_next_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
                level_next_s[i] = s_s[i];
                cnt_next_s[i]   = CNT_ZERO;
                accept_s[i]     = 1'b1;
            end else begin
                cnt_next_s[i] = cnt_r[i] + CNT_ONE;
            end

            // Enables are sampled at the acceptance edge; s is the new level.
            event_s[i] = accept_s[i] &
                         ((s_s[i] & rise_en[i]) | (~s_s[i] & fall_en[i]));

            // A retrigger reloads the counter rather than adding to it.
            if (event_s[i]) begin
                pcnt_next_s[i] = PCNT_LOAD;
            end else if (pcnt_r[i] != PCNT_ZERO) begin
                pcnt_next_s[i] = pcnt_r[i] - PCNT_ONE;
            end else begin
                pcnt_next_s[i] = PCNT_ZERO;
            end
            pulse_next_s[i] = (pcnt_next_s[i] != PCNT_ZERO);

            // Set wins over a simultaneous clear.
            pending_next_s[i] = event_s[i] | (pending_r[i] & ~clear[i]);
        end
    end

    // State registers: synchroniser chain, debounce/pulse counters and outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= {WIDTH{1'b0}};
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i]  <= CNT_ZERO;
                pcnt_r[i] <= PCNT_ZERO;
            end
            level_r     <= {WIDTH{1'b0}};
            pulse_r     <= {WIDTH{1'b0}};
            pending_r   <= {WIDTH{1'b0}};
            any_event_r <= 1'b0;
        end else begin
            sync_r[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i]  <= cnt_next_s[i];
                pcnt_r[i] <= pcnt_next_s[i];
            end
            level_r     <= level_next_s;
            pulse_r     <= pulse_next_s;
            pending_r   <= pending_next_s;
            any_event_r <= |pending_next_s;
        end
    end

    assign level     = level_r;
    assign pulse     = pulse_r;
    assign pending   = pending_r;
    assign any_event = any_event_r;

endmodule

// File: tb/tb_multi_edge_detect.sv
// -----------------------------------------------------------------------------
// tb_multi_edge_detect
//
// Randomised self-checking bench. The reference model keeps a history of the
// raw samples and accepts a new level when the last DEBOUNCE_CYCLES
// synchronised samples all disagree with the current level; pulses are modelled
// as a remaining-time count and pending as a set/clear flag.
// -----------------------------------------------------------------------------
module tb_multi_edge_detect;

    localparam int W = 4;
    localparam int S = 2;
    localparam int D = 3;
    localparam int P = 3;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] in;
    logic [W-1:0] rise_en;
    logic [W-1:0] fall_en;
    logic [W-1:0] clear;
    logic [W-1:0] level;
    logic [W-1:0] pulse;
    logic [W-1:0] pending;
    logic         any_event;

    multi_edge_detect #(
        .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .PULSE_LEN(P)
    ) dut (
        .clock(clock), .reset(reset), .in(in), .rise_en(rise_en),
        .fall_en(fall_en), .clear(clear), .level(level), .pulse(pulse),
        .pending(pending), .any_event(any_event)
    );

    always #5 clock = ~clock;

    int n_vectors = 0;
    int n_errors  = 0;
    int cycle     = 0;

    // Reference model state. hist[0] is the sample taken at the previous edge.
    logic [W-1:0] hist [S+D];
    logic [W-1:0] m_level;
    logic [W-1:0] m_pending;
    int           m_left [W];

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cycle, got, exp);
        end
    endtask

    task automatic model_edge();
        logic all_new;
        logic ev;
        if (reset) begin
            for (int j = 0; j < S + D; j++) hist[j] = '0;
            m_level   = '0;
            m_pending = '0;
            for (int c = 0; c < W; c++) m_left[c] = 0;
        end else begin
            for (int c = 0; c < W; c++) begin
                // Synchronised sample seen at edge t-j is hist[S-1+j].
                all_new = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (hist[S-1+j][c] == m_level[c]) all_new = 1'b0;
                end
                ev = 1'b0;
                if (all_new) begin
                    m_level[c] = ~m_level[c];
                    ev = m_level[c] ? rise_en[c] : fall_en[c];
                end
                if (ev) m_left[c] = P;
                else if (m_left[c] > 0) m_left[c] = m_left[c] - 1;
                if (ev) m_pending[c] = 1'b1;
                else if (clear[c]) m_pending[c] = 1'b0;
            end
            for (int j = S + D - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = in;
        end
    endtask

    task automatic step(input logic [W-1:0] i_in, input logic [W-1:0] i_re,
                        input logic [W-1:0] i_fe, input logic [W-1:0] i_clr,
                        input logic i_rst);
        logic [W-1:0] exp_pulse;
        in      = i_in;
        rise_en = i_re;
        fall_en = i_fe;
        clear   = i_clr;
        reset   = i_rst;
        @(posedge clock);
        model_edge();
        cycle++;
        #1;
        for (int c = 0; c < W; c++) exp_pulse[c] = (m_left[c] > 0);
        check_val("level",     32'(level),     32'(m_level));
        check_val("pulse",     32'(pulse),     32'(exp_pulse));
        check_val("pending",   32'(pending),   32'(m_pending));
        check_val("any_event", 32'(any_event), 32'(|m_pending));
    endtask

    initial begin
        logic [W-1:0] cur_in;
        logic [W-1:0] flip;
        logic [W-1:0] clr;
        logic         rst;

        in = '0; rise_en = '0; fall_en = '0; clear = '0; reset = 1'b1;
        for (int j = 0; j < S + D; j++) hist[j] = '0;
        m_level = '0; m_pending = '0;
        for (int c = 0; c < W; c++) m_left[c] = 0;
        #2;

        // Reset state.
        repeat (3) step(4'h0, 4'hF, 4'hF, 4'h0, 1'b1);

        // Inputs held high through reset give rising events after latency.
        repeat (2) step(4'hF, 4'hF, 4'h0, 4'h0, 1'b1);
        repeat (8) step(4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
        // Clear coincident with nothing new: pending drops.
        step(4'hF, 4'hF, 4'h0, 4'hF, 1'b0);
        // Falls with enable only on channel 2, then retrigger mid-pulse.
        repeat (4) step(4'h0, 4'h0, 4'h4, 4'h0, 1'b0);
        repeat (D + 1) step(4'h4, 4'h0, 4'h4, 4'h0, 1'b0);
        repeat (D + S) step(4'h0, 4'h0, 4'h4, 4'h0, 1'b0);
        repeat (6) step(4'h0, 4'h0, 4'h4, 4'h0, 1'b0);
        // Reset in the middle of pulses.
        repeat (D + S - 1) step(4'h5, 4'hF, 4'hF, 4'h0, 1'b0);
        step(4'h5, 4'hF, 4'hF, 4'h0, 1'b1);
        repeat (8) step(4'h5, 4'hF, 4'hF, 4'h0, 1'b0);

        // Random phase: slowly changing inputs with glitches, random enables,
        // clears and occasional resets.
        cur_in = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < W; c++) begin
                flip[c] = ($urandom_range(0, 4) == 0);
                clr[c]  = ($urandom_range(0, 3) == 0);
            end
            cur_in = cur_in ^ flip;
            rst    = ($urandom_range(0, 199) == 0);
            step(cur_in, W'($urandom), W'($urandom), clr, rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_errors);
        $finish;
    end

endmodule
